// File: rtl/sintable_arbiter.sv
// sintable_arbiter: round-robin arbiter sharing one pipelined sine table among NREQ requesters.
// Each accepted phase is issued to the table and its requester ID rides a tag pipeline
// aligned with the table latency, so every returned sample comes back tagged with its ID.
// Optional build macro: SINTABLE_ARB_COSINE_EN (cosine requests get a quarter-turn offset).
module sintable_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 8,
    parameter int DW   = 8,
    parameter int LAT  = 1,
    parameter int IDW  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*PW-1:0]   i_req_phase,
    input  logic [NREQ-1:0]      i_req_cos,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [PW-1:0]        o_tbl_phase,
    output logic                 o_tbl_valid,
    input  logic [DW-1:0]        i_tbl_data,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [DW-1:0]        o_rsp_data,
    output logic                 o_busy
);

    // Round-robin pointer: index searched first in the next arbitration
    logic [IDW-1:0]          ptr_q, ptr_d;

    // Arbitration results
    logic [NREQ-1:0]         grant;
    logic                    win_found;
    logic [IDW-1:0]          win_id;
    logic [PW-1:0]           win_phase;
    logic [PW-1:0]           iss_phase;
    logic                    xfer;

    // Issue stage (drives the table)
    logic [PW-1:0]           tbl_phase_q, tbl_phase_d;
    logic                    tbl_valid_q, tbl_valid_d;
    logic [IDW-1:0]          iss_id_q, iss_id_d;

    // Tag pipeline, LAT deep, aligned with the table read latency
    logic [LAT-1:0]          tag_v_q, tag_v_d;
    logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;

    // Response stage
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [DW-1:0]           rsp_data_q, rsp_data_d;

    // Search valids starting at the pointer, wrapping; first set bit wins
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        win_found = 1'b0;
        win_id    = '0;
        win_phase = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found  = 1'b1;
                win_id     = IDW'(idx);
                win_phase  = i_req_phase[idx*PW +: PW];
                grant[idx] = 1'b1;
            end
        end
    end

    // Ready is suppressed while reset is held so nothing is accepted into a clearing pipe
    assign o_req_ready = grant & {NREQ{i_reset_n}};
    assign xfer        = win_found & i_reset_n;

`ifdef SINTABLE_ARB_COSINE_EN
    // Cosine requests are issued a quarter turn ahead; the add wraps modulo 2^PW
    always_comb begin
        iss_phase = win_phase;
        if (i_req_cos[win_id]) begin
            iss_phase = win_phase + PW'(1 << (PW - 2));
        end
    end
`else
    // Cosine select has no effect in this build
    logic unused_cos;
    assign unused_cos = ^i_req_cos;
    assign iss_phase  = win_phase;
`endif

    // Pointer advance and issue-stage next state
    always_comb begin
        ptr_d       = ptr_q;
        tbl_valid_d = xfer;
        tbl_phase_d = tbl_phase_q;
        iss_id_d    = iss_id_q;
        if (xfer) begin
            ptr_d       = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
            tbl_phase_d = iss_phase;
            iss_id_d    = win_id;
        end
    end

    // Tag pipeline shifts every cycle, fed from the issue stage
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = tbl_valid_q;
        tag_id_d[0] = iss_id_q;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    // Tail of the tag pipe meets the table output; ID/data hold when no response
    always_comb begin
        rsp_valid_d = tag_v_q[LAT-1];
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (tag_v_q[LAT-1]) begin
            rsp_id_d   = tag_id_q[LAT-1];
            rsp_data_d = i_tbl_data;
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q       <= '0;
            tbl_phase_q <= '0;
            tbl_valid_q <= 1'b0;
            iss_id_q    <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tbl_phase_q <= tbl_phase_d;
            tbl_valid_q <= tbl_valid_d;
            iss_id_q    <= iss_id_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign o_tbl_phase = tbl_phase_q;
    assign o_tbl_valid = tbl_valid_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = (|tag_v_q) | tbl_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_sintable_arbiter.sv
// tb_sintable_arbiter: directed bench with a round-robin reference model, a sine-table model
// and a scoreboard of expected {id, sample, arrival cycle} checked on every response.
module tb_sintable_arbiter;

    localparam int NREQ = 4;
    localparam int PW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*PW-1:0]   req_phase;
    logic [NREQ-1:0]      req_cos;
    logic [NREQ-1:0]      req_ready;
    logic [PW-1:0]        tbl_phase;
    logic                 tbl_valid;
    logic [DW-1:0]        tbl_data;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_data;
    logic                 busy;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   m_ptr;
    logic exp_tbl_valid;
    logic [PW-1:0] exp_tbl_phase;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sintable_arbiter #(
        .NREQ (NREQ),
        .PW   (PW),
        .DW   (DW),
        .LAT  (LAT),
        .IDW  (IDW)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req_valid (req_valid),
        .i_req_phase (req_phase),
        .i_req_cos   (req_cos),
        .o_req_ready (req_ready),
        .o_tbl_phase (tbl_phase),
        .o_tbl_valid (tbl_valid),
        .i_tbl_data  (tbl_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    function automatic logic [DW-1:0] model_sin(input logic [PW-1:0] p);
        real r;
        r = $sin(6.283185307179586 * real'(p) / 256.0) * 127.0;
        return DW'(int'(r));
    endfunction

    function automatic logic [PW-1:0] exp_issue(input logic [PW-1:0] p, input logic c);
        logic [PW-1:0] off;
        off = 8'h40;
`ifndef SINTABLE_ARB_COSINE_EN
        off = 8'h00;
`endif
        return c ? p + off : p;
    endfunction

    // Pipelined sine table model with LAT clocks of read latency
    logic [DW-1:0] tbl_pipe [LAT];
    always @(posedge clk) begin
        tbl_pipe[0] <= model_sin(tbl_phase);
        for (int i = 1; i < LAT; i++) tbl_pipe[i] <= tbl_pipe[i-1];
    end
    assign tbl_data = tbl_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            vec_cnt++;
            assert (sb.size() != 0) else begin
                err_cnt++;
                $error("FAIL unexpected_rsp observed id=%0d expected no response", rsp_id);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*PW-1:0] ph,
                        input logic [NREQ-1:0] cs);
        int   idx;
        int   id;
        logic found;
        logic [NREQ-1:0] exp_rdy;
        logic [PW-1:0]   p;
        req_valid = v;
        req_phase = ph;
        req_cos   = cs;
        @(negedge clk);
        chk("tbl_valid", 32'(tbl_valid), 32'(exp_tbl_valid));
        chk("tbl_phase", 32'(tbl_phase), 32'(exp_tbl_phase));
        found = 1'b0;
        id    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (m_ptr + i) % NREQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
        exp_rdy = found ? (NREQ'(1) << id) : '0;
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        exp_tbl_valid = found;
        if (found) begin
            p             = ph[id*PW +: PW];
            exp_tbl_phase = exp_issue(p, cs[id]);
            sb.push_back('{id: IDW'(id), data: model_sin(exp_tbl_phase), cyc: cyc + LAT + 2});
            m_ptr = (id + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step('0, '0, '0);
            n++;
        end
        vec_cnt++;
        assert (sb.size() == 0) else begin
            err_cnt++;
            $error("FAIL drain_timeout observed pending=%0d expected 0", sb.size());
        end
        sb.delete();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '1;
        req_phase     = '0;
        req_cos       = '0;
        m_ptr         = 0;
        exp_tbl_valid = 1'b0;
        exp_tbl_phase = '0;

        // Reset held with every request valid
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_tbl_phase", 32'(tbl_phase), 32'd0);
        chk("rst_tbl_valid", 32'(tbl_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All valid: strict rotation starting at 0, phases 0x10*k
        repeat (8) step(4'hF, 32'h3020_1000, 4'h0);
        drain();

        // Single accept from requester 2, phase 0x40
        step(4'b0100, 32'h0040_0000, 4'h0);
        chk("busy_in_flight", 32'(busy), 32'd1);
        drain();

        // Pointer now 3; only 1 and 3 valid, phase 0xFF passes unmodified
        repeat (3) step(4'b1010, 32'hFF00_0100, 4'h0);
        drain();

        // Reset mid-flight discards three in-flight requests
        repeat (3) step(4'hF, 32'h4433_2211, 4'h0);
        rst_n     = 1'b0;
        req_valid = '0;
        sb.delete();
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tbl_valid", 32'(tbl_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        m_ptr         = 0;
        exp_tbl_valid = 1'b0;
        exp_tbl_phase = '0;
        repeat (6) step('0, '0, '0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Grants resume at requester 0
        step(4'hF, 32'h0807_0605, 4'h0);

        // Cosine select on requester 0 with phase 0xF0
        step(4'b0001, 32'h0000_00F0, 4'b0001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sintable_arbiter.md
Name: sintable_arbiter

Overview:
- Round-robin arbiter sharing one pipelined sine lookup table (sintable: 8-bit phase in, 8-bit sample out) among NREQ requesters.
- Accepts at most one phase request per cycle and drives the table.
- Tracks requester IDs through the table latency; returns each sample tagged with its requester ID.
- Sits between NCO/modulator channels and the single sintable instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PW, 8, phase width (matches sintable i_data).
- DW, 8, sample width (matches sintable o_data).
- LAT, 1, sintable read latency in clocks (1..4).
- IDW, 2, requester ID width; must be ≥ clog2(NREQ).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_phase  in  NREQ*PW  packed phases; requester k at bits [k*PW +: PW].
- i_req_cos  in  NREQ  per-requester cosine select; used only with the optional feature.
- o_req_ready  out  NREQ  one-hot grant/accept.
- o_tbl_phase  out  PW  phase to sintable i_data.
- o_tbl_valid  out  1  table issue strobe, for debug/power gating.
- i_tbl_data  in  DW  sintable o_data.
- o_rsp_valid  out  1  response valid, single-cycle pulse.
- o_rsp_id  out  IDW  requester ID of response.
- o_rsp_data  out  DW  sine sample.
- o_busy  out  1  high while any issued request is still in flight.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - o_tbl_phase=0, o_tbl_valid=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_busy=0.
  - RR pointer=0; tag pipeline cleared.
- Arbitration (combinational):
  - Search i_req_valid starting at index ptr, wrapping at NREQ-1→0; first set bit wins.
  - o_req_ready = one-hot of the winner; all zero if no valid.
  - Ready never asserts without the matching valid.
- Handshake:
  - Transfer occurs when i_req_valid[k] & o_req_ready[k].
  - A requester must hold valid and phase stable until accepted; dropping valid early is allowed and simply cancels.
- Pointer: on a transfer by k, ptr <= (k+1) mod NREQ. With no transfer, ptr holds.
- Issue stage (registered), on transfer in cycle T:
  - o_tbl_phase <= phase_k; o_tbl_valid <= 1.
  - Tag stage 0 <= {1, k}.
  - With no transfer: o_tbl_valid <= 0 and o_tbl_phase holds its value.
- Tag pipeline:
  - LAT registers of {valid, id}, shifted every cycle, aligned with the table latency.
  - At the tail, o_rsp_data <= i_tbl_data, o_rsp_id <= id, o_rsp_valid <= valid.
- Latency: accept in cycle T → o_rsp_valid high in cycle T+LAT+2. Throughput is 1 request/clock.
- o_rsp_id, o_rsp_data: hold the last response value when o_rsp_valid=0.
- Backpressure: none on the response side; the consumer must always accept.
- o_busy: OR of all tag-pipeline valid bits, the issue-stage valid, and o_rsp_valid.
- Boundary conditions:
  - All NREQ valid continuously → strict rotation 0,1,...,NREQ-1,0. No starvation; max wait NREQ-1 cycles.
  - Single requester held valid → accepted every cycle.
  - A request arriving in the same cycle as a response → both proceed; no conflict.
  - Phase wrap: phase is passed unmodified; 0xFF is legal.
  - Reset mid-operation: all in-flight responses are discarded; no o_rsp_valid after deassert until a new accept.

Optional Feature:
- Macro: SINTABLE_ARB_COSINE_EN.
- Defined:
  - On accept, if i_req_cos[k]=1, issued phase = phase_k + 2^(PW-2) mod 2^PW, giving a quarter-turn offset (cosine).
  - The response carries the cos flag internally only; o_rsp_id is unchanged.
- Undefined: i_req_cos is ignored and phase is always issued unmodified.

Test Plan:
- Reset: hold i_reset_n=0 with all i_req_valid=1 → all outputs 0, o_req_ready=0. Release → first grant to requester 0.
- Single accept:
  - Stimulus: req 2 valid, phase 0x40, in cycle T (LAT=1).
  - Required: o_req_ready=4'b0100 in T; o_tbl_phase=0x40 and o_tbl_valid=1 in T+1.
  - Required: o_rsp_valid=1, o_rsp_id=2, o_rsp_data=model_sin(0x40) in T+3, single pulse.
- Round-robin: all 4 valid for 8 cycles with phases 0x10*k → grant order 0,1,2,3,0,1,2,3; response IDs in the same order, back-to-back.
- Fairness/wrap:
  - Stimulus: ptr=3 with only reqs 1 and 3 valid.
  - Required: grant 3, then 1, then 3; phase 0xFF passes through as 0xFF.
- Reset mid-flight: accept 3 requests, assert i_reset_n=0 for 1 cycle → no o_rsp_valid ever follows; o_busy=0.
- SINTABLE_ARB_COSINE_EN: req 0, phase 0xF0, cos=1 → o_tbl_phase=0x30. Without the macro → o_tbl_phase=0xF0.
